// File: rtl/soc_pkg.sv
// Shared constants for the SoC interrupt controller: register map,
// data width and default source count.
package soc_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned N_IRQ_DEFAULT = 8;

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_MASK    = 3'd1,
    REG_EDGE    = 3'd2,
    REG_ACK     = 3'd3,
    REG_ACTIVE  = 3'd4,
    REG_FORCE   = 3'd5
  } reg_addr_e;

endpackage

// File: rtl/soc_irq_ctrl_if.sv
// Avalon-style register slave bus used by the interrupt controller.
interface soc_irq_ctrl_if;
  import soc_pkg::*;

  logic              chipselect;
  logic              write_n;
  logic [2:0]        address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, write_n, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write_n, address, writedata,
    output readdata
  );

endinterface

// File: rtl/soc_irq_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous interrupt request.
module soc_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages_q;
  logic [SYNC_STAGES-1:0] stages_d;

  always_comb begin
    stages_d = {stages_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stages_q <= '0;
    else          stages_q <= stages_d;
  end

  assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/soc_irq_ctrl.sv
// Interrupt controller: synchronizes raw requests, latches level/edge pending
// state, masks, priority-encodes and exposes everything over a register bus.
module soc_irq_ctrl
  import soc_pkg::*;
#(
  parameter int unsigned N_IRQ       = N_IRQ_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] irq_in,
  soc_irq_ctrl_if.slave    bus,
  output logic             irq,
  output logic [2:0]       irq_id
);

  logic [N_IRQ-1:0]  sync;
  logic [N_IRQ-1:0]  sync_prev_q, sync_prev_d;
  logic [N_IRQ-1:0]  pending_q, pending_d;
  logic [N_IRQ-1:0]  mask_q, mask_d;
  logic [N_IRQ-1:0]  edge_q, edge_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic [2:0]        irq_id_q, irq_id_d;

  logic [N_IRQ-1:0]  active;
  logic [N_IRQ-1:0]  wdata_bits;
  logic [N_IRQ-1:0]  ack_bits, force_bits, edge_set;
  logic              wr_en;
  logic              any_active;
  logic [2:0]        enc_id;
  logic              unused_wdata;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    soc_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (irq_in[g]),
      .q       (sync[g])
    );
  end

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdata_bits   = bus.writedata[N_IRQ-1:0];
  assign unused_wdata = ^bus.writedata[DATA_W-1:N_IRQ];
  assign active       = pending_q & mask_q;

  // Bit 0 has highest priority, so scan downward and let the lowest index win.
  always_comb begin
    enc_id     = '0;
    any_active = |active;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (active[i-1]) enc_id = 3'(i - 1);
    end
  end

  always_comb begin
    ack_bits    = (wr_en && bus.address == REG_ACK)   ? wdata_bits : '0;
    force_bits  = (wr_en && bus.address == REG_FORCE) ? wdata_bits : '0;
    edge_set    = (sync & ~sync_prev_q) | force_bits;
    sync_prev_d = sync;
    // Edge sources: set wins over ACK. Level sources simply track sync.
    pending_d   = (edge_q & (edge_set | (pending_q & ~ack_bits))) | (~edge_q & sync);

    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en && bus.address == REG_MASK) mask_d = wdata_bits;
    if (wr_en && bus.address == REG_EDGE) edge_d = wdata_bits;

    readdata_d = '0;
    if (bus.chipselect && bus.write_n) begin
      case (bus.address)
        REG_PENDING: readdata_d = DATA_W'(pending_q);
        REG_MASK:    readdata_d = DATA_W'(mask_q);
        REG_EDGE:    readdata_d = DATA_W'(edge_q);
        REG_ACTIVE:  readdata_d = {any_active, 12'd0, enc_id};
        default:     readdata_d = '0;
      endcase
    end

    irq_d    = any_active;
    irq_id_d = enc_id;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_prev_q <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      edge_q      <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      sync_prev_q <= sync_prev_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;
  assign irq_id       = irq_id_q;

endmodule

// File: tb/tb_soc_irq_ctrl.sv
// Directed self-checking bench for soc_irq_ctrl: register table plus
// hand-written latency, edge/ACK, priority, mask and reset sequences.
module tb_soc_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       irq;
  logic [2:0] irq_id;

  int errors = 0;
  int checks = 0;

  soc_irq_ctrl_if bus ();

  soc_irq_ctrl #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .bus     (bus),
    .irq     (irq),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    tick();
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    logic [15:0] rdata;

    vecs[0] = '{3'd1, 16'h00A5, 16'h00A5};
    vecs[1] = '{3'd1, 16'hFF3C, 16'h003C};
    vecs[2] = '{3'd2, 16'h1234, 16'h0034};
    vecs[3] = '{3'd6, 16'hFFFF, 16'h0000};
    vecs[4] = '{3'd7, 16'h1234, 16'h0000};
    vecs[5] = '{3'd2, 16'h0000, 16'h0000};
    vecs[6] = '{3'd1, 16'h0000, 16'h0000};
    vecs[7] = '{3'd0, 16'hFFFF, 16'h0000};
    vecs[8] = '{3'd5, 16'h00FF, 16'h0000};
    vecs[9] = '{3'd4, 16'hFFFF, 16'h0000};

    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;

    #12;
    check("reset_irq", 16'(irq), 16'h0);
    check("reset_irq_id", 16'(irq_id), 16'h0);
    check("reset_readdata", bus.readdata, 16'h0);
    reset_n = 1'b1;
    ticks(2);
    rd(3'd1, rdata); check("reset_mask", rdata, 16'h0);
    rd(3'd2, rdata); check("reset_edge", rdata, 16'h0);

    // Register table: write then read back the same offset.
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, rdata);
      check($sformatf("reg_vec%0d", i), rdata, vecs[i].exp);
    end
    // FORCE on a level source must not set pending.
    rd(3'd0, rdata); check("level_force_ignored", rdata, 16'h0);

    // Level source latency: driven after edge 0, irq at edge 4.
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    ticks(3);
    check("level_irq_edge3", 16'(irq), 16'h0);
    tick();
    check("level_irq_edge4", 16'(irq), 16'h1);
    check("level_irq_id", 16'(irq_id), 16'h0);
    irq_in[0] = 1'b0;
    ticks(3);
    check("level_fall_edge3", 16'(irq), 16'h1);
    tick();
    check("level_fall_edge4", 16'(irq), 16'h0);

    // Edge source with ACK.
    wr(3'd2, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    ticks(6);
    rd(3'd0, rdata); check("edge_pending", rdata, 16'h0004);
    check("edge_irq_held", 16'(irq), 16'h1);
    wr(3'd3, 16'h0004);
    check("ack_irq_next", 16'(irq), 16'h1);
    tick();
    check("ack_irq_dropped", 16'(irq), 16'h0);

    // Priority encoding with FORCE/ACK.
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h00FF);
    wr(3'd5, 16'h000A);
    rd(3'd4, rdata); check("prio_active_1", rdata, 16'h8001);
    check("prio_irq_id_1", 16'(irq_id), 16'h1);
    wr(3'd3, 16'h0002);
    rd(3'd4, rdata); check("prio_active_3", rdata, 16'h8003);
    check("prio_irq_id_3", 16'(irq_id), 16'h3);
    wr(3'd3, 16'h0008);
    tick();
    check("prio_cleared_irq", 16'(irq), 16'h0);

    // Edge arriving in the same cycle as ACK: set wins.
    wr(3'd5, 16'h0020);
    irq_in[5] = 1'b1;
    ticks(2);
    wr(3'd3, 16'h0020);
    rd(3'd0, rdata); check("simul_set_wins", rdata, 16'h0020);
    wr(3'd3, 16'h0020);
    rd(3'd0, rdata); check("ack_no_new_edge", rdata, 16'h0000);
    irq_in[5] = 1'b0;
    ticks(4);

    // Masked pending does not raise irq until unmasked.
    wr(3'd1, 16'h0000);
    wr(3'd5, 16'h0080);
    rd(3'd0, rdata); check("mask_pending", rdata, 16'h0080);
    check("mask_irq_off", 16'(irq), 16'h0);
    wr(3'd1, 16'h0080);
    check("unmask_irq_write_edge", 16'(irq), 16'h0);
    tick();
    check("unmask_irq_on", 16'(irq), 16'h1);
    check("unmask_irq_id", 16'(irq_id), 16'h7);

    // Mid-operation asynchronous reset.
    wr(3'd1, 16'h00FF);
    wr(3'd5, 16'h00FF);
    rd(3'd0, rdata); check("pre_reset_pending", rdata, 16'h00FF);
    check("pre_reset_irq", 16'(irq), 16'h1);
    bus.chipselect = 1'b1;
    bus.address    = 3'd0;
    tick();
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", 16'(irq), 16'h0);
    check("async_reset_readdata", bus.readdata, 16'h0);
    bus.chipselect = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    rd(3'd0, rdata); check("post_reset_pending", rdata, 16'h0);
    ticks(4);
    check("post_reset_irq", 16'(irq), 16'h0);
    rd(3'd1, rdata); check("post_reset_mask", rdata, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
